shifter_pipe: RTL and testbench



---
 rtl/shifter_pkg.sv | 37 +++
 rtl/shifter_amt_dec.sv | 80 ++++++++
 rtl/shifter_pipe.sv | 192 +++++++++++++++++++
 tb/tb_shifter_pipe.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared types for the pipelined ARM shifter-operand unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shifter_pkg;

    // Source of the shift amount / operand.
    typedef enum logic [1:0] {
        SRC_ROT_IMM   = 2'd0,
        SRC_SHIFT_IMM = 2'd1,
        SRC_REG       = 2'd2,
        SRC_PASS      = 2'd3
    } shift_src_t;

    // Shift operation applied to the operand.
    typedef enum logic [1:0] {
        LSL = 2'd0,
        LSR = 2'd1,
        ASR = 2'd2,
        ROR = 2'd3
    } shift_type_t;

    // Amount field is wide enough for a full Rs[7:0] byte.
    localparam int AMT_W = 8;

    // S1 control payload: everything the barrel shifter and carry select need
    // besides the operand itself.
    typedef struct packed {
        shift_type_t        typ;       // effective operation (imm-rotate forces ROR)
        logic [AMT_W-1:0]   amount;    // shift/rotate distance, valid when !ge_width
        logic               zero_amt;  // pass operand and c_in unchanged
        logic               ge_width;  // amount >= WIDTH (LSL/LSR/ASR saturation)
        logic               eq_width;  // amount == WIDTH (selects the edge carry bit)
        logic               rrx;       // rotate-right-extended through carry
        logic               c_in;      // CPSR C captured with the request
    } s1_ctrl_t;

endpackage

// File: rtl/shifter_amt_dec.sv
// Decodes src/type/immediate fields into shift amount and mode flags for S1.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller registers the result only on accept.
module shifter_amt_dec
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  shift_src_t          src_i,
    input  shift_type_t         type_i,
    input  logic [3:0]          rotate_imm_i,
    input  logic [SHAMT_W-1:0]  shift_imm_i,
    input  logic [7:0]          rs_lo_i,
    output shift_type_t         type_o,
    output logic [AMT_W-1:0]    amount_o,
    output logic                zero_amt_o,
    output logic                ge_width_o,
    output logic                eq_width_o,
    output logic                rrx_o,
    output logic                use_imm_o
);

    // Register amounts are compared at 9 bits so an 8-bit amount never wraps.
    localparam logic [8:0]       WIDTH9   = 9'(WIDTH);
    localparam logic [AMT_W-1:0] AMT_MASK = AMT_W'(WIDTH - 1);

    logic [8:0] a9;
    assign a9 = {1'b0, rs_lo_i};

    // Select amount and special-case flags for each source.
    always_comb begin
        type_o     = type_i;
        amount_o   = '0;
        zero_amt_o = 1'b0;
        ge_width_o = 1'b0;
        eq_width_o = 1'b0;
        rrx_o      = 1'b0;
        use_imm_o  = 1'b0;
        case (src_i)
            SRC_ROT_IMM: begin
                use_imm_o  = 1'b1;
                type_o     = ROR;
                amount_o   = AMT_W'({rotate_imm_i, 1'b0}) & AMT_MASK;
                zero_amt_o = (rotate_imm_i == 4'd0);
            end
            SRC_SHIFT_IMM: begin
                amount_o = AMT_W'(shift_imm_i);
                if (shift_imm_i == '0) begin
                    case (type_i)
                        LSL:     zero_amt_o = 1'b1;
                        LSR,
                        ASR: begin
                            // Encoded zero means a full-width shift.
                            ge_width_o = 1'b1;
                            eq_width_o = 1'b1;
                        end
                        ROR:     rrx_o = 1'b1;
                        default: zero_amt_o = 1'b1;
                    endcase
                end
            end
            SRC_REG: begin
                if (rs_lo_i == 8'd0) begin
                    zero_amt_o = 1'b1;
                end else if (type_i == ROR) begin
                    amount_o = rs_lo_i & AMT_MASK;
                end else begin
                    amount_o   = rs_lo_i;
                    ge_width_o = (a9 >= WIDTH9);
                    eq_width_o = (a9 == WIDTH9);
                end
            end
            default: begin
                zero_amt_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined ARM shifter operand: S1 decodes/captures, S2 shifts and registers op/carry.
// Latency: 2 cycles accept-to-out_valid, 1/cycle throughput with out_ready high.
// Backpressure: each stage holds when its successor is full and stalled; in_ready is combinational.
// Optional: SHIFTER_ZERO_FLAG_EN adds a registered out_zero flag.
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_src,
    input  logic [1:0]          in_type,
    input  logic [3:0]          rotate_imm,
    input  logic [7:0]          imm8,
    input  logic [SHAMT_W-1:0]  shift_imm,
    input  logic [WIDTH-1:0]    rs,
    input  logic [WIDTH-1:0]    rm,
    input  logic                c_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_operand,
    output logic                out_carry
`ifdef SHIFTER_ZERO_FLAG_EN
    ,
    output logic                out_zero
`endif
);

    // Stage state.
    logic               s1_v_q;
    s1_ctrl_t           s1_ctrl_q, s1_ctrl_d;
    logic [WIDTH-1:0]   s1_opnd_q, s1_opnd_d;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_operand_q, op_d;
    logic               out_carry_q, carry_d;

    logic s1_adv, s2_adv;

    // Decoder outputs.
    shift_type_t        dec_type;
    logic [AMT_W-1:0]   dec_amount;
    logic               dec_zero_amt, dec_ge_width, dec_eq_width, dec_rrx, dec_use_imm;

    // Only Rs[7:0] carries an amount; amount bits above SHAMT_W matter only via ge_width.
    logic unused_bits;
    assign unused_bits = ^{rs[WIDTH-1:8], s1_ctrl_q.amount};

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_v_q || s2_adv;
    assign in_ready = s1_adv && !reset;

    shifter_amt_dec #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_amt_dec (
        .src_i        (shift_src_t'(in_src)),
        .type_i       (shift_type_t'(in_type)),
        .rotate_imm_i (rotate_imm),
        .shift_imm_i  (shift_imm),
        .rs_lo_i      (rs[7:0]),
        .type_o       (dec_type),
        .amount_o     (dec_amount),
        .zero_amt_o   (dec_zero_amt),
        .ge_width_o   (dec_ge_width),
        .eq_width_o   (dec_eq_width),
        .rrx_o        (dec_rrx),
        .use_imm_o    (dec_use_imm)
    );

    // Assemble the S1 payload; immediate-rotate shifts the zero-extended imm8.
    always_comb begin
        s1_ctrl_d.typ      = dec_type;
        s1_ctrl_d.amount   = dec_amount;
        s1_ctrl_d.zero_amt = dec_zero_amt;
        s1_ctrl_d.ge_width = dec_ge_width;
        s1_ctrl_d.eq_width = dec_eq_width;
        s1_ctrl_d.rrx      = dec_rrx;
        s1_ctrl_d.c_in     = c_in;
        s1_opnd_d          = dec_use_imm ? WIDTH'(imm8) : rm;
    end

    // Barrel shift and carry select from the S1 registers.
    logic [WIDTH-1:0]   x;
    logic [SHAMT_W-1:0] sh, sh_m1, sh_neg;
    assign x      = s1_opnd_q;
    assign sh     = s1_ctrl_q.amount[SHAMT_W-1:0];
    assign sh_m1  = sh - SHAMT_W'(1);
    assign sh_neg = SHAMT_W'(0) - sh;

    // Shift result and carry-out for the captured request.
    always_comb begin
        op_d    = x;
        carry_d = s1_ctrl_q.c_in;
        if (s1_ctrl_q.rrx) begin
            op_d    = {s1_ctrl_q.c_in, x[WIDTH-1:1]};
            carry_d = x[0];
        end else if (!s1_ctrl_q.zero_amt) begin
            case (s1_ctrl_q.typ)
                LSL: begin
                    if (s1_ctrl_q.ge_width) begin
                        op_d    = '0;
                        carry_d = s1_ctrl_q.eq_width & x[0];
                    end else begin
                        op_d    = x << sh;
                        carry_d = x[sh_neg];
                    end
                end
                LSR: begin
                    if (s1_ctrl_q.ge_width) begin
                        op_d    = '0;
                        carry_d = s1_ctrl_q.eq_width & x[WIDTH-1];
                    end else begin
                        op_d    = x >> sh;
                        carry_d = x[sh_m1];
                    end
                end
                ASR: begin
                    if (s1_ctrl_q.ge_width) begin
                        op_d    = {WIDTH{x[WIDTH-1]}};
                        carry_d = x[WIDTH-1];
                    end else begin
                        op_d    = WIDTH'($signed(x) >>> sh);
                        carry_d = x[sh_m1];
                    end
                end
                default: begin
                    // Rotate by a multiple of WIDTH leaves the operand, carry is its MSB.
                    if (sh == '0) begin
                        carry_d = x[WIDTH-1];
                    end else begin
                        op_d    = (x >> sh) | (x << sh_neg);
                        carry_d = x[sh_m1];
                    end
                end
            endcase
        end
    end

    // S1: capture decoded request when the stage can advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q    <= 1'b0;
            s1_ctrl_q <= '0;
            s1_opnd_q <= '0;
        end else if (s1_adv) begin
            s1_v_q <= in_valid;
            if (in_valid) begin
                s1_ctrl_q <= s1_ctrl_d;
                s1_opnd_q <= s1_opnd_d;
            end
        end
    end

    // S2: register operand/carry; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_operand_q <= '0;
            out_carry_q   <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_v_q;
            if (s1_v_q) begin
                out_operand_q <= op_d;
                out_carry_q   <= carry_d;
            end
        end
    end

`ifdef SHIFTER_ZERO_FLAG_EN
    logic out_zero_q;

    // Zero flag registered alongside the operand, same stall behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_zero_q <= 1'b0;
        end else if (s2_adv && s1_v_q) begin
            out_zero_q <= (op_d == '0);
        end
    end

    assign out_zero = out_zero_q;
`endif

    assign out_valid   = out_valid_q;
    assign out_operand = out_operand_q;
    assign out_carry   = out_carry_q;

endmodule

// File: tb/tb_shifter_pipe.sv
// Self-checking bench for shifter_pipe: directed table, stall/reset sequences, random traffic.
// Latency: checks the 2-cycle accept-to-valid path.
// Backpressure: exercises held out_ready and random out_ready.
module tb_shifter_pipe;

    localparam int W = 32;

    typedef struct {
        logic [1:0]  src;
        logic [1:0]  typ;
        logic [3:0]  rot;
        logic [7:0]  imm8;
        logic [4:0]  shimm;
        logic [31:0] rs;
        logic [31:0] rm;
        logic        c;
    } req_t;

    typedef struct {
        req_t        r;
        logic [31:0] op;
        logic        cy;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_src = '0;
    logic [1:0]  in_type = '0;
    logic [3:0]  rotate_imm = '0;
    logic [7:0]  imm8 = '0;
    logic [4:0]  shift_imm = '0;
    logic [31:0] rs = '0;
    logic [31:0] rm = '0;
    logic        c_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_operand;
    logic        out_carry;
`ifdef SHIFTER_ZERO_FLAG_EN
    logic        out_zero;
`endif

    int n_chk = 0;
    int n_pass = 0;
    int n_pop = 0;
    logic [32:0] scb_q[$];

    shifter_pipe #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_src      (in_src),
        .in_type     (in_type),
        .rotate_imm  (rotate_imm),
        .imm8        (imm8),
        .shift_imm   (shift_imm),
        .rs          (rs),
        .rm          (rm),
        .c_in        (c_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_operand (out_operand),
        .out_carry   (out_carry)
`ifdef SHIFTER_ZERO_FLAG_EN
        ,
        .out_zero    (out_zero)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model (arithmetic on double-width vectors) ----------------
    function automatic logic [32:0] m_lsl(logic [31:0] x, int a);
        logic [63:0] e;
        e = {32'h0, x} << a;
        return {e[32], e[31:0]};
    endfunction

    function automatic logic [32:0] m_lsr(logic [31:0] x, int a);
        logic [63:0] e;
        e = {x, 32'h0} >> a;
        return {e[31], e[63:32]};
    endfunction

    function automatic logic [32:0] m_asr(logic [31:0] x, int a);
        logic signed [63:0] e;
        e = {x, 32'h0};
        e = e >>> a;
        return {e[31], e[63:32]};
    endfunction

    // Rotate one bit at a time; carry is the last bit moved out.
    function automatic logic [32:0] m_ror(logic [31:0] x, int k);
        logic [31:0] v;
        logic        cy;
        v  = x;
        cy = 1'b0;
        for (int i = 0; i < k; i++) begin
            cy = v[0];
            v  = {v[0], v[31:1]};
        end
        return {cy, v};
    endfunction

    function automatic logic [32:0] model(req_t r);
        logic [32:0] res;
        int          a, n, k;
        res = {r.c, r.rm};
        case (r.src)
            2'd0: begin
                res = m_ror({24'h0, r.imm8}, 2 * int'(r.rot));
                res[32] = (r.rot == 0) ? r.c : res[31];
            end
            2'd1: begin
                n = int'(r.shimm);
                case (r.typ)
                    2'd0: res = (n == 0) ? {r.c, r.rm} : m_lsl(r.rm, n);
                    2'd1: res = m_lsr(r.rm, (n == 0) ? W : n);
                    2'd2: res = m_asr(r.rm, (n == 0) ? W : n);
                    default: res = (n == 0) ? {r.rm[0], r.c, r.rm[31:1]} : m_ror(r.rm, n);
                endcase
            end
            2'd2: begin
                a = int'(r.rs[7:0]);
                if (a != 0) begin
                    case (r.typ)
                        2'd0: res = m_lsl(r.rm, a);
                        2'd1: res = m_lsr(r.rm, a);
                        2'd2: res = m_asr(r.rm, a);
                        default: begin
                            k = a % W;
                            res = (k == 0) ? {r.rm[31], r.rm} : m_ror(r.rm, k);
                        end
                    endcase
                end
            end
            default: res = {r.c, r.rm};
        endcase
        return res;
    endfunction

    // ---------------- driving ----------------
    task automatic apply(input req_t r);
        in_src     = r.src;
        in_type    = r.typ;
        rotate_imm = r.rot;
        imm8       = r.imm8;
        shift_imm  = r.shimm;
        rs         = r.rs;
        rm         = r.rm;
        c_in       = r.c;
    endtask

    // Present a request, wait (bounded) for acceptance, return just after the accepting edge.
    task automatic send(input req_t r);
        int n;
        apply(r);
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 300);
        if (!in_ready) begin
            n_chk++;
            $display("FAIL send_timeout: in_ready low for %0d cycles, required 1", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.src   = 2'($urandom_range(0, 3));
        r.typ   = 2'($urandom_range(0, 3));
        r.rot   = 4'($urandom);
        r.imm8  = 8'($urandom);
        r.shimm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        r.rs    = $urandom;
        case ($urandom_range(0, 6))
            0: r.rs[7:0] = 8'd0;
            1: r.rs[7:0] = 8'd31;
            2: r.rs[7:0] = 8'd32;
            3: r.rs[7:0] = 8'd33;
            4: r.rs[7:0] = 8'd64;
            default: ;
        endcase
        r.rm = $urandom;
        r.c  = 1'($urandom);
        return r;
    endfunction

    // ---------------- scoreboard monitor ----------------
    initial begin
        req_t        r;
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (in_valid && in_ready) begin
                    r.src = in_src; r.typ = in_type; r.rot = rotate_imm; r.imm8 = imm8;
                    r.shimm = shift_imm; r.rs = rs; r.rm = rm; r.c = c_in;
                    scb_q.push_back(model(r));
                end
                if (out_valid && out_ready) begin
                    n_pop++;
                    if (scb_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL scb_spurious: output 0x%0h popped with no outstanding request", out_operand);
                    end else begin
                        e = scb_q.pop_front();
                        check("scb_op", 64'(out_operand), 64'(e[31:0]));
                        check("scb_carry", 64'(out_carry), 64'(e[32]));
`ifdef SHIFTER_ZERO_FLAG_EN
                        check("scb_zero", 64'(out_zero), 64'(e[31:0] == 32'h0));
`endif
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        vec_t        tbl[14];
        req_t        rq[4];
        logic [32:0] e0;
        int          waited, base, seen;
        bit          done;

        tbl[0]  = '{'{2'd0, 2'd0, 4'd4, 8'hFF, 5'd0, 32'h0, 32'h0, 1'b0}, 32'hFF000000, 1'b1};
        tbl[1]  = '{'{2'd0, 2'd0, 4'd0, 8'hFF, 5'd0, 32'h0, 32'h0, 1'b0}, 32'h000000FF, 1'b0};
        tbl[2]  = '{'{2'd1, 2'd1, 4'd0, 8'h00, 5'd0, 32'h0, 32'h80000001, 1'b0}, 32'h00000000, 1'b1};
        tbl[3]  = '{'{2'd1, 2'd2, 4'd0, 8'h00, 5'd0, 32'h0, 32'h80000001, 1'b0}, 32'hFFFFFFFF, 1'b1};
        tbl[4]  = '{'{2'd1, 2'd3, 4'd0, 8'h00, 5'd0, 32'h0, 32'h00000003, 1'b1}, 32'h80000001, 1'b1};
        tbl[5]  = '{'{2'd2, 2'd0, 4'd0, 8'h00, 5'd0, 32'd32, 32'h1, 1'b0}, 32'h0, 1'b1};
        tbl[6]  = '{'{2'd2, 2'd0, 4'd0, 8'h00, 5'd0, 32'd33, 32'h1, 1'b0}, 32'h0, 1'b0};
        tbl[7]  = '{'{2'd2, 2'd0, 4'd0, 8'h00, 5'd0, 32'h100, 32'h1, 1'b1}, 32'h1, 1'b1};
        tbl[8]  = '{'{2'd2, 2'd3, 4'd0, 8'h00, 5'd0, 32'd32, 32'h80000000, 1'b0}, 32'h80000000, 1'b1};
        tbl[9]  = '{'{2'd1, 2'd0, 4'd0, 8'h00, 5'd4, 32'h0, 32'hF000000F, 1'b0}, 32'h000000F0, 1'b1};
        tbl[10] = '{'{2'd3, 2'd2, 4'd7, 8'h55, 5'd9, 32'd5, 32'h12345678, 1'b1}, 32'h12345678, 1'b1};
        tbl[11] = '{'{2'd2, 2'd2, 4'd0, 8'h00, 5'd0, 32'd40, 32'h7FFFFFFF, 1'b1}, 32'h00000000, 1'b0};
        tbl[12] = '{'{2'd2, 2'd1, 4'd0, 8'h00, 5'd0, 32'd4, 32'h0000001F, 1'b0}, 32'h00000001, 1'b1};
        tbl[13] = '{'{2'd0, 2'd0, 4'd1, 8'h03, 5'd0, 32'h0, 32'h0, 1'b0}, 32'hC0000000, 1'b1};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_operand", 64'(out_operand), 64'd0);
        check("rst_out_carry", 64'(out_carry), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed table, one request at a time.
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            send(tbl[i].r);
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!out_valid && waited < 20);
            check($sformatf("tbl%0d_op", i), 64'(out_operand), 64'(tbl[i].op));
            check($sformatf("tbl%0d_carry", i), 64'(out_carry), 64'(tbl[i].cy));
            check($sformatf("tbl%0d_latency", i), 64'(waited), 64'd2);
            @(posedge clk);
            #1;
        end

        // Stall: four back-to-back requests against a held-off consumer.
        out_ready = 1'b0;
        base = n_pop;
        for (int i = 0; i < 4; i++) rq[i] = rand_req();
        e0 = model(rq[0]);
        send(rq[0]);
        send(rq[1]);
        apply(rq[2]);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_op", 64'(out_operand), 64'(e0[31:0]));
            check("stall_carry", 64'(out_carry), 64'(e0[32]));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(rq[2]);
        send(rq[3]);
        waited = 0;
        while (n_pop - base < 4 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        repeat (4) @(negedge clk);
        check("stall_pop_count", 64'(n_pop - base), 64'd4);
        @(posedge clk);
        #1;

        // Reset with two requests in flight.
        out_ready = 1'b0;
        send(rand_req());
        send(rand_req());
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        scb_q.delete();
        base = n_pop;
        @(negedge clk);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid_rst_no_stale", 64'(seen), 64'd0);
        check("mid_rst_no_pop", 64'(n_pop - base), 64'd0);
        @(posedge clk);
        #1;

        // Random traffic with random consumer backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(rand_req());
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        waited = 0;
        while (scb_q.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("drain_empty", 64'(scb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
